// File: rtl/multicycle_sequencer.sv
// Main control FSM for a multicycle RV32I datapath: steps each latched
// instruction through fetch, decode, execute and writeback states.
module multicycle_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       sign,
    input  logic       carry,
    input  logic       overflow,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LINK     = 4'd12,
        UPPER    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RD2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALU_REG  = 2'b00;
    localparam logic [1:0] RES_MEM      = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    state_t state_q;
    state_t state_d;

    // funct7b5 only turns add into sub for register ops; shifts honour it in both forms
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s,
                                          input logic c, input logic v);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = s ^ v;
            3'b101:  taken = !(s ^ v);
            3'b110:  taken = !c;
            3'b111:  taken = c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_REG:            state_d = EXECR;
                    OP_IMM:            state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI, OP_AUIPC:  state_d = UPPER;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            JALR:     state_d = LINK;
            LINK:     state_d = ALUWB;
            UPPER:    state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALU_REG;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RD2;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            DECODE: begin
                // precompute the branch/jal target into alu_reg ahead of execute
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal = 1'b0;
                    default:                           illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALU_REG;
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALU_REG;
                mem_write  = 1'b1;
            end
            EXECR: begin
                alu_src_a   = SRC_A_RD1;
                alu_src_b   = SRC_B_RD2;
                alu_control = alu_decode(funct3, funct7b5, 1'b1);
            end
            EXECI: begin
                alu_src_a   = SRC_A_RD1;
                alu_src_b   = SRC_B_IMM;
                imm_src     = IMM_I;
                alu_control = alu_decode(funct3, funct7b5, 1'b0);
            end
            ALUWB: begin
                result_src = RES_ALU_REG;
                reg_write  = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = SRC_A_RD1;
                alu_src_b   = SRC_B_RD2;
                alu_control = ALU_SUB;
                result_src  = RES_ALU_REG;
                pc_write    = branch_taken(funct3, zero, sign, carry, overflow);
                illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            JAL: begin
                result_src = RES_ALU_REG;
                pc_write   = 1'b1;
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
            end
            JALR: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_IMM;
                imm_src    = IMM_I;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            LINK: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
            end
            UPPER: begin
                imm_src   = IMM_U;
                alu_src_b = SRC_B_IMM;
                alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks instruction classes through
// the FSM and checks state codes and control outputs against hand-computed values.
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       sign;
    logic       carry;
    logic       overflow;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .sign       (sign),
        .carry      (carry),
        .overflow   (overflow),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                                  input logic z, input logic s, input logic c, input logic v);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7b5;
        zero     = z;
        sign     = s;
        carry    = c;
        overflow = v;
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("rst_state", state, 0);
        check_output("rst_pc_write", pc_write, 0);
        check_output("rst_ir_write", ir_write, 0);

        reset = 1'b0;
        #1;
        check_output("fetch_ir_write", ir_write, 1);
        check_output("fetch_pc_write", pc_write, 1);
        check_output("fetch_src_b", alu_src_b, 2);
        check_output("fetch_result_src", result_src, 2);
        check_output("fetch_adr_src", adr_src, 0);

        // R-type sub
        apply_stimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("r_decode_state", state, 1);
        check_output("r_decode_src_a", alu_src_a, 1);
        check_output("r_decode_imm", imm_src, 2);
        check_output("r_decode_reg_write", reg_write, 0);
        step();
        check_output("r_exec_state", state, 6);
        check_output("r_exec_alu", alu_control, 4'b0001);
        check_output("r_exec_reg_write", reg_write, 0);
        step();
        check_output("r_wb_state", state, 8);
        check_output("r_wb_reg_write", reg_write, 1);
        check_output("r_wb_result_src", result_src, 0);
        step();
        check_output("r_back_fetch", state, 0);

        // load word
        apply_stimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("ld_decode_state", state, 1);
        step();
        check_output("ld_memadr_state", state, 2);
        check_output("ld_memadr_imm", imm_src, 0);
        check_output("ld_memadr_src_a", alu_src_a, 2);
        step();
        check_output("ld_memread_state", state, 3);
        check_output("ld_memread_adr_src", adr_src, 1);
        step();
        check_output("ld_memwb_state", state, 4);
        check_output("ld_memwb_result_src", result_src, 1);
        check_output("ld_memwb_reg_write", reg_write, 1);
        step();
        check_output("ld_back_fetch", state, 0);

        // bne not equal: taken
        apply_stimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("bne_state", state, 9);
        check_output("bne_taken", pc_write, 1);
        check_output("bne_alu", alu_control, 4'b0001);
        check_output("bne_illegal", illegal, 0);
        step();
        check_output("bne_back_fetch", state, 0);

        // bne equal: not taken
        apply_stimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("bne_eq_pc_write", pc_write, 0);
        step();

        // blt with sign=1, overflow=0: taken
        apply_stimulus(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check_output("blt_taken", pc_write, 1);
        step();

        // bgeu with borrow (carry=0): not taken
        apply_stimulus(7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("bgeu_not_taken", pc_write, 0);
        step();

        // reserved branch funct3
        apply_stimulus(7'b1100011, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        check_output("br011_illegal", illegal, 1);
        check_output("br011_pc_write", pc_write, 0);
        step();
        check_output("br011_back_fetch", state, 0);

        // jalr
        apply_stimulus(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("jalr_decode_state", state, 1);
        step();
        check_output("jalr_state", state, 11);
        check_output("jalr_pc_write", pc_write, 1);
        check_output("jalr_result_src", result_src, 2);
        check_output("jalr_imm", imm_src, 0);
        step();
        check_output("link_state", state, 12);
        check_output("link_src_a", alu_src_a, 1);
        check_output("link_src_b", alu_src_b, 2);
        step();
        check_output("jalr_wb_state", state, 8);
        step();
        check_output("jalr_back_fetch", state, 0);

        // jal
        apply_stimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("jal_decode_imm", imm_src, 4);
        step();
        check_output("jal_state", state, 10);
        check_output("jal_pc_write", pc_write, 1);
        step();
        check_output("jal_wb_state", state, 8);
        step();

        // illegal opcode
        apply_stimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("ill_decode_state", state, 1);
        check_output("ill_flag", illegal, 1);
        check_output("ill_mem_write", mem_write, 0);
        check_output("ill_reg_write", reg_write, 0);
        step();
        check_output("ill_back_fetch", state, 0);
        check_output("ill_flag_clear", illegal, 0);

        // srai: funct7b5 selects sra
        apply_stimulus(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("srai_state", state, 7);
        check_output("srai_alu", alu_control, 4'b0111);
        check_output("srai_src_b", alu_src_b, 1);
        step();
        step();

        // addi with funct7b5 set stays add
        apply_stimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("addi_alu", alu_control, 4'b0000);
        step();
        step();

        // lui
        apply_stimulus(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("lui_state", state, 13);
        check_output("lui_src_a", alu_src_a, 3);
        check_output("lui_imm", imm_src, 3);
        step();
        step();

        // store, then reset asserted during MEMWRITE
        apply_stimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_output("st_memadr_imm", imm_src, 1);
        step();
        check_output("st_memwrite_state", state, 5);
        check_output("st_mem_write", mem_write, 1);
        check_output("st_adr_src", adr_src, 1);
        reset = 1'b1;
        #1;
        check_output("st_rst_mem_write", mem_write, 0);
        step();
        check_output("st_rst_state", state, 0);
        check_output("st_rst_ir_write", ir_write, 0);
        reset = 1'b0;
        #1;
        check_output("post_rst_ir_write", ir_write, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
